// File: rtl/alu_ctrl_pkg.sv
// ALU control codes shared by the ALU controller and the execute-stage ALU.
package alu_ctrl_pkg;

  localparam int CTRL_W = 5;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDI = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTI = 5'd6;
  localparam logic [4:0] ALU_BEQ  = 5'd7;
  localparam logic [4:0] ALU_BNE  = 5'd8;
  localparam logic [4:0] ALU_ORI  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;
  localparam logic [4:0] ALU_SRLV = 5'd12;
  localparam logic [4:0] ALU_LW   = 5'd13;
  localparam logic [4:0] ALU_SW   = 5'd14;
  localparam logic [4:0] ALU_J    = 5'd15;
  localparam logic [4:0] ALU_MULT = 5'd16;
  localparam logic [4:0] ALU_BGEZ = 5'd17;
  localparam logic [4:0] ALU_BLT  = 5'd18;

endpackage

// File: rtl/ex_alu_unit_mult_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, DATA_W
// iterations. done_o is high during the last busy cycle and product_o then
// carries the final (low DATA_W bits) product, so the caller can register it
// on the same edge that retires the last iteration.
module mult_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_next;

  // Accumulator value after the current iteration's conditional add.
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CNT_LAST);
  assign busy_o    = busy_q;
  assign product_o = acc_next;

  // Start latches operands; each busy cycle retires one multiplier bit.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end
  end

  // State registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle ops and branch resolution with registered
// outputs, plus an iterative multiply that stalls the pipeline while busy.
module ex_alu_unit #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              branch_o
);

  import alu_ctrl_pkg::*;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic              state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              branch_q, branch_d;

  logic              accept;
  logic              is_mult;
  logic [DATA_W-1:0] alu_res;
  logic              alu_br;
  logic              mult_busy;
  logic              mult_done;
  logic [DATA_W-1:0] mult_prod;

  logic signed [DATA_W-1:0] s1_s;
  logic signed [DATA_W-1:0] s2_s;

  assign s1_s    = $signed(src1_i);
  assign s2_s    = $signed(src2_i);
  assign accept  = valid_i && (state_q == ST_IDLE);
  assign is_mult = (ctrl_i == CTRL_W'(ALU_MULT));
  assign stall_o = (state_q == ST_BUSY);

  mult_iter #(.DATA_W(DATA_W)) u_mult (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept && is_mult),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .busy_o    (mult_busy),
    .done_o    (mult_done),
    .product_o (mult_prod)
  );

  // Single-cycle result and branch decision for the current control code.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (ctrl_i)
      CTRL_W'(ALU_ADD), CTRL_W'(ALU_ADDI),
      CTRL_W'(ALU_LW),  CTRL_W'(ALU_SW):   alu_res = src1_i + src2_i;
      CTRL_W'(ALU_SUB):                    alu_res = src1_i - src2_i;
      CTRL_W'(ALU_AND):                    alu_res = src1_i & src2_i;
      CTRL_W'(ALU_OR), CTRL_W'(ALU_ORI):   alu_res = src1_i | src2_i;
      CTRL_W'(ALU_SLT), CTRL_W'(ALU_SLTI): alu_res = {{(DATA_W-1){1'b0}}, (s1_s < s2_s)};
      CTRL_W'(ALU_SRL):                    alu_res = src2_i >> shamt_i;
      CTRL_W'(ALU_SRLV):                   alu_res = src2_i >> src1_i[4:0];
      CTRL_W'(ALU_LUI):                    alu_res = src2_i << 16;
      CTRL_W'(ALU_BEQ): begin
        alu_res = src1_i - src2_i;
        alu_br  = (src1_i == src2_i);
      end
      CTRL_W'(ALU_BNE): begin
        alu_res = src1_i - src2_i;
        alu_br  = (src1_i != src2_i);
      end
      CTRL_W'(ALU_BGEZ): begin
        alu_res = src1_i;
        alu_br  = (s1_s >= 0);
      end
      CTRL_W'(ALU_BLT): begin
        alu_res = src1_i - src2_i;
        alu_br  = (s1_s < s2_s);
      end
      default: begin
        alu_res = '0;
        alu_br  = 1'b0;
      end
    endcase
  end

  // IDLE/BUSY control and next values of the output registers.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    branch_d = branch_q;
    if (state_q == ST_IDLE) begin
      if (accept && is_mult) begin
        state_d = ST_BUSY;
      end else if (accept) begin
        valid_d  = 1'b1;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        branch_d = alu_br;
      end
    end else if (mult_busy && mult_done) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b1;
      result_d = mult_prod;
      zero_d   = (mult_prod == '0);
      branch_d = 1'b0;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign branch_o = branch_q;

endmodule
